// File: rtl/spm_sched_pkg.sv
// ---------------------------------------------------------------------------
// spm_sched_pkg
// Shared definitions for the scratchpad access scheduler:
//   - state_e        : scheduler FSM states
//   - ADDR_SHIFT     : word-to-byte address shift (32-bit words)
//   - *_WID_DEF      : default scratchpad address / data widths
//   - byteAddr()     : external byte address from base + word address
// ---------------------------------------------------------------------------
package spm_sched_pkg;

    localparam int ADDR_WID_DEF = 13;
    localparam int DATA_WID_DEF = 32;
    localparam int ADDR_SHIFT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_WAIT_A,
        ST_WAIT_B,
        ST_DONE
    } state_e;

    // Converts a zero-extended word address into a byte address off a base.
    function automatic logic [63:0] byteAddr(input logic [63:0] base,
                                             input logic [63:0] wordAddr);
        return base + (wordAddr << ADDR_SHIFT);
    endfunction

endpackage

// File: rtl/spm_port_latch.sv
// ---------------------------------------------------------------------------
// spm_port_latch
// Captures one scratchpad port request (ce/we/addr/d) at the end of an
// accelerator step and holds it as a pending access until it completes.
// While capture_i is high the outputs pass the live request through, so the
// scheduler can decide on the same edge that performs the capture.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   capture_i         high during the accelerator step cycle
//   clear_i           the pending access completed this cycle
//   ce_i/we_i/addr_i/d_i   live port request from the accelerator
//   pending_o/we_o/addr_o/d_o   effective (live in step, else latched) request
// ---------------------------------------------------------------------------
module spm_port_latch
    import spm_sched_pkg::*;
#(
    parameter int ADDR_WID = ADDR_WID_DEF,
    parameter int DATA_WID = DATA_WID_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                capture_i,
    input  logic                clear_i,
    input  logic                ce_i,
    input  logic                we_i,
    input  logic [ADDR_WID-1:0] addr_i,
    input  logic [DATA_WID-1:0] d_i,
    output logic                pending_o,
    output logic                we_o,
    output logic [ADDR_WID-1:0] addr_o,
    output logic [DATA_WID-1:0] d_o
);

    logic                pending_q;
    logic                we_q;
    logic [ADDR_WID-1:0] addr_q;
    logic [DATA_WID-1:0] d_q;

    // Request capture at the step edge; the pending flag drops on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            d_q       <= '0;
        end else if (capture_i) begin
            pending_q <= ce_i;
            we_q      <= we_i;
            addr_q    <= addr_i;
            d_q       <= d_i;
        end else if (clear_i) begin
            pending_q <= 1'b0;
        end
    end

    assign pending_o = capture_i ? ce_i   : pending_q;
    assign we_o      = capture_i ? we_i   : we_q;
    assign addr_o    = capture_i ? addr_i : addr_q;
    assign d_o       = capture_i ? d_i    : d_q;

endmodule

// File: rtl/spm_access_sched.sv
// ---------------------------------------------------------------------------
// spm_access_sched
// Steps an HLS accelerator through a clock-enable, latches both scratchpad
// port requests of each step and serialises them (A before B) onto a
// single-beat external read/write channel. Read data returns to the
// accelerator with one step of latency; a done pulse reports completion.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   start                           begins a run (honoured only in IDLE)
//   read_base, write_base           external byte base addresses
//   read_size_input                 size forwarded with each access
//   acc_ce / acc_done / acc_ret     accelerator enable, done, return value
//   a_* / b_*                       scratchpad port requests and read data
//   read_* / write_*                external channel (one-cycle enables)
//   done / returnvalue              completion pulse and captured result
//   step_cnt / access_cnt           performance counters
//
// Configuration:
//   SPM_SCHED_PERF_CNT_EN  when defined, step_cnt/access_cnt count step
//                          cycles and completed accesses (saturating);
//                          otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module spm_access_sched
    import spm_sched_pkg::*;
#(
    parameter int ADDR_WID = ADDR_WID_DEF,
    parameter int DATA_WID = DATA_WID_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [63:0]         read_base,
    input  logic [63:0]         write_base,
    input  logic [63:0]         read_size_input,
    output logic                acc_ce,
    input  logic                acc_done,
    input  logic [DATA_WID-1:0] acc_ret,
    input  logic                a_ce,
    input  logic                a_we,
    input  logic                b_ce,
    input  logic                b_we,
    input  logic [ADDR_WID-1:0] a_addr,
    input  logic [ADDR_WID-1:0] b_addr,
    input  logic [DATA_WID-1:0] a_d,
    input  logic [DATA_WID-1:0] b_d,
    output logic [DATA_WID-1:0] a_q,
    output logic [DATA_WID-1:0] b_q,
    output logic                read_enable,
    output logic                write_enable,
    output logic [63:0]         read_addr,
    output logic [63:0]         write_addr,
    output logic [63:0]         read_size_output,
    output logic [63:0]         write_size,
    output logic [31:0]         write_data,
    input  logic                read_ready,
    input  logic                write_ready,
    input  logic [31:0]         read_data,
    output logic                done,
    output logic [DATA_WID-1:0] returnvalue,
    output logic [63:0]         step_cnt,
    output logic [63:0]         access_cnt
);

    state_e state_q, state_d;

    logic                capture;
    logic                aPend, aWe, bPend, bWe;
    logic [ADDR_WID-1:0] aAddr, bAddr;
    logic [DATA_WID-1:0] aD, bD;
    logic                readyA, readyB;
    logic                issueA, issueB, completeA, completeB;
    logic                issue, issueWe;
    logic [ADDR_WID-1:0] issueAddr;
    logic [DATA_WID-1:0] issueData;
    logic                doneLatch_q, doneEff;

    logic                readEn_q, writeEn_q;
    logic [63:0]         readAddr_q, writeAddr_q, readSize_q, writeSize_q;
    logic [31:0]         writeData_q;
    logic [DATA_WID-1:0] aQ_q, bQ_q, retVal_q;

    assign capture = (state_q == ST_STEP);

    spm_port_latch #(.ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID)) uPortA (
        .clk       (clk),
        .reset     (reset),
        .capture_i (capture),
        .clear_i   (completeA),
        .ce_i      (a_ce),
        .we_i      (a_we),
        .addr_i    (a_addr),
        .d_i       (a_d),
        .pending_o (aPend),
        .we_o      (aWe),
        .addr_o    (aAddr),
        .d_o       (aD)
    );

    spm_port_latch #(.ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID)) uPortB (
        .clk       (clk),
        .reset     (reset),
        .capture_i (capture),
        .clear_i   (completeB),
        .ce_i      (b_ce),
        .we_i      (b_we),
        .addr_i    (b_addr),
        .d_i       (b_d),
        .pending_o (bPend),
        .we_o      (bWe),
        .addr_o    (bAddr),
        .d_o       (bD)
    );

    // acc_done is only meaningful at the step edge; keep it for after the
    // step's accesses have drained.
    assign doneEff = capture ? acc_done : doneLatch_q;

    // Only the ready line matching the outstanding access kind counts.
    assign readyA = aWe ? write_ready : read_ready;
    assign readyB = bWe ? write_ready : read_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and issue/complete decisions. Port A is always drained
    // before port B so same-word hazards resolve in program order.
    always_comb begin
        state_d   = state_q;
        issueA    = 1'b0;
        issueB    = 1'b0;
        completeA = 1'b0;
        completeB = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (aPend) begin
                    issueA  = 1'b1;
                    state_d = ST_WAIT_A;
                end else if (bPend) begin
                    issueB  = 1'b1;
                    state_d = ST_WAIT_B;
                end else if (doneEff) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_WAIT_A: begin
                if (readyA) begin
                    completeA = 1'b1;
                    if (bPend) begin
                        issueB  = 1'b1;
                        state_d = ST_WAIT_B;
                    end else if (doneEff) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_WAIT_B: begin
                if (readyB) begin
                    completeB = 1'b1;
                    state_d   = doneEff ? ST_DONE : ST_STEP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign issue     = issueA | issueB;
    assign issueWe   = issueA ? aWe   : bWe;
    assign issueAddr = issueA ? aAddr : bAddr;
    assign issueData = issueA ? aD    : bD;

    // External channel registers: enables pulse for the first wait cycle,
    // address/size/data hold until the next access of the same kind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readEn_q    <= 1'b0;
            writeEn_q   <= 1'b0;
            readAddr_q  <= '0;
            writeAddr_q <= '0;
            readSize_q  <= '0;
            writeSize_q <= '0;
            writeData_q <= '0;
        end else begin
            readEn_q  <= issue & ~issueWe;
            writeEn_q <= issue & issueWe;
            if (issue && !issueWe) begin
                readAddr_q <= byteAddr(read_base, 64'(issueAddr));
                readSize_q <= read_size_input;
            end
            if (issue && issueWe) begin
                writeAddr_q <= byteAddr(write_base, 64'(issueAddr));
                writeSize_q <= read_size_input;
                writeData_q <= 32'(issueData);
            end
        end
    end

    // Read data returned to the accelerator, latched done flag and the
    // return value captured on the way into DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aQ_q        <= '0;
            bQ_q        <= '0;
            doneLatch_q <= 1'b0;
            retVal_q    <= '0;
        end else begin
            if (completeA && !aWe) aQ_q <= DATA_WID'(read_data);
            if (completeB && !bWe) bQ_q <= DATA_WID'(read_data);
            if (capture) doneLatch_q <= acc_done;
            if (state_d == ST_DONE && state_q != ST_DONE) retVal_q <= acc_ret;
        end
    end

`ifdef SPM_SCHED_PERF_CNT_EN
    logic [63:0] stepCnt_q, accessCnt_q;

    // Saturating performance counters, cleared by a run start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stepCnt_q   <= '0;
            accessCnt_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            stepCnt_q   <= '0;
            accessCnt_q <= '0;
        end else begin
            if (capture && stepCnt_q != '1) stepCnt_q <= stepCnt_q + 64'd1;
            if ((completeA || completeB) && accessCnt_q != '1)
                accessCnt_q <= accessCnt_q + 64'd1;
        end
    end

    assign step_cnt   = stepCnt_q;
    assign access_cnt = accessCnt_q;
`else
    assign step_cnt   = 64'd0;
    assign access_cnt = 64'd0;
`endif

    assign acc_ce           = (state_q == ST_STEP);
    assign done             = (state_q == ST_DONE);
    assign read_enable      = readEn_q;
    assign write_enable     = writeEn_q;
    assign read_addr        = readAddr_q;
    assign write_addr       = writeAddr_q;
    assign read_size_output = readSize_q;
    assign write_size       = writeSize_q;
    assign write_data       = writeData_q;
    assign a_q              = aQ_q;
    assign b_q              = bQ_q;
    assign returnvalue      = retVal_q;

endmodule

// File: doc/spm_access_sched.md
# spm_access_sched

Scratchpad access scheduler placed between an HLS accelerator's two-port scratchpad interface (ports A/B) and the single-beat external memory read/write channel. Replaces accelerator clock gating with a clock-enable: it advances the accelerator one step, latches both port requests, serializes them onto the external channel (A before B), returns read data with one-step BRAM latency, and reports completion.

## Interface
- ADDR_WID, 13, scratchpad word-address width
- DATA_WID, 32, data width

- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse in IDLE begins a run
- read_base, write_base  in  64  byte base addresses
- read_size_input  in  64  size forwarded on every access
- acc_ce  out  1  accelerator clock-enable; one step per high cycle
- acc_done  in  1  accelerator done (ap_done)
- acc_ret  in  DATA_WID  accelerator return value
- a_ce, a_we, b_ce, b_we  in  1  port requests
- a_addr, b_addr  in  ADDR_WID  word addresses
- a_d, b_d  in  DATA_WID  write data
- a_q, b_q  out  DATA_WID  read data returned to the accelerator
- read_enable, write_enable  out  1  one-cycle request pulses
- read_addr, write_addr  out  64  byte address = base + (addr<<2)
- read_size_output, write_size  out  64  = read_size_input at issue
- write_data  out  32  write payload
- read_ready, write_ready  in  1  external completion
- read_data  in  32  external read data
- done  out  1  one-cycle completion pulse
- returnvalue  out  DATA_WID  acc_ret captured at completion
- step_cnt, access_cnt  out  64  performance counters (see Configuration)

## Operation
- States: IDLE, STEP, WAIT_A, WAIT_B, DONE.
- IDLE: acc_ce=0; start=1 → STEP; start ignored in any other state.
- STEP: acc_ce=1 for this cycle; at its edge latch a_ce/a_we/a_addr/a_d, b_*, acc_done. Next: A pending → issue A, WAIT_A; else B pending → issue B, WAIT_B; else acc_done → DONE; else STEP (back-to-back steps).
- Issue: load addr/size/data registers, assert read_enable or write_enable for exactly the first cycle of the WAIT state.
- WAIT_A: ready (read_ready for reads, write_ready for writes) sampled every cycle including the first; on ready: read → a_q<=read_data; then B pending → issue B, WAIT_B; else latched done → DONE; else STEP.
- WAIT_B: on ready: read → b_q<=read_data; latched done → DONE, else STEP.
- DONE: done=1, returnvalue<=acc_ret (captured on entry); → IDLE.
- a_q/b_q hold until overwritten by a later read on the same port; writes never alter them.
- Same-address hazards: A always completes before B; A write + B read same word → B sees A's data; both write → B's value remains.
- acc_done with pending requests: requests served first, then DONE.

## Timing
- Reset (reset=0, async): state IDLE; all outputs 0 (acc_ce, enables, done, addrs, sizes, write_data, a_q, b_q, returnvalue, counters).
- Reset mid-wait: outstanding access abandoned; no enable re-issued after release.
- Step with no accesses: 1 cycle. Step with one access: 1 + N cycles, N ≥ 1 = cycles until ready. Two accesses: 1 + N_A + N_B.
- Ready while not in a matching WAIT state: ignored.
- Accelerator sees BRAM read latency of exactly one step.

## Configuration
- SPM_SCHED_PERF_CNT_EN defined: step_cnt increments per STEP cycle, access_cnt per completed external access; both clear on reset and on start in IDLE, saturate at 2^64-1.
- Undefined: counter logic absent; step_cnt and access_cnt tied to 0.

## Structure
- Package spm_sched_pkg: state enum, address shift constant (2), default widths.
- One sub-module spm_port_latch (instantiated twice): captures ce/we/addr/d at STEP, holds pending flag, clears on completion.

## Test plan
- start; step 1 a_ce=1,a_we=0,a_addr=5, read_base=0x1000 → read_addr=0x1014 one-cycle read_enable; read_ready after 3 cycles with 0xCAFE → a_q=0xCAFE, next state STEP.
- a write addr 7 data 0x11 and b read addr 7 same step → write issued first (write_addr=write_base+0x1C), then read; b_q = read_data returned.
- No requests for 4 steps → acc_ce high 4 consecutive cycles, enables never asserted.
- acc_done=1 with b read pending, acc_ret=42 → read served, then done pulse 1 cycle, returnvalue=42, IDLE.
- reset=0 during WAIT_B → all outputs 0 immediately; after release stays IDLE until start.
- With SPM_SCHED_PERF_CNT_EN: 3 steps, 2 accesses → step_cnt=3, access_cnt=2; without → both 0.
